// File: rtl/fetch_stage.sv
// fetch_stage: program counter plus the IF/ID pipeline register.
// Decoded instruction fields are plain slices of the registered word, so the
// decoder and control unit only ever see IF/ID state.
// A taken branch wins over a stall and flushes IF/ID with a bubble. A stall
// freezes both the PC and IF/ID.
// Optional build macro FETCH_PERF_EN adds saturating counters for fetches,
// stalls and flushes.
module fetch_stage #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP_WORD = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_data,
    output logic [31:0]     if_id_instr,
    output logic [PC_W-1:0] if_id_pc4,
    output logic            if_id_valid,
    output logic [5:0]      op,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      shamt,
    output logic [5:0]      funct,
    output logic [15:0]     imm
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stalls,
    output logic [31:0]     perf_flushes
`endif
);

    logic [PC_W-1:0] pcReg;
    logic [PC_W-1:0] pcPlus4;
    logic [PC_W-1:0] branchAligned;
    logic            doBranch;
    logic            doStall;
    logic            doAdvance;

    // The +4 wraps modulo 2^PC_W, and the redirect target is forced to a word boundary.
    assign pcPlus4       = pcReg + PC_W'(4);
    assign branchAligned = {branch_target[PC_W-1:2], 2'b00};

    // The per-edge action is chosen in priority order: branch, then stall, then advance.
    assign doBranch  = branch_taken;
    assign doStall   = !branch_taken && stall;
    assign doAdvance = !branch_taken && !stall;

    assign imem_addr = pcReg;

    // Program counter: redirect on a taken branch, hold on a stall, otherwise step by one word.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcReg <= RESET_PC;
        end else if (doBranch) begin
            pcReg <= branchAligned;
        end else if (doAdvance) begin
            pcReg <= pcPlus4;
        end
    end

    // IF/ID register: a flush inserts the bubble, a stall holds, otherwise it captures the fetched word.
    always_ff @(posedge clk) begin
        if (rst || doBranch) begin
            if_id_instr <= NOP_WORD;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
        end else if (doAdvance) begin
            if_id_instr <= imem_data;
            if_id_pc4   <= pcPlus4;
            if_id_valid <= 1'b1;
        end
    end

    // Instruction fields are pure slices of IF/ID, with no extra register stage.
    assign op    = if_id_instr[31:26];
    assign rs    = if_id_instr[25:21];
    assign rt    = if_id_instr[20:16];
    assign rd    = if_id_instr[15:11];
    assign shamt = if_id_instr[10:6];
    assign funct = if_id_instr[5:0];
    assign imm   = if_id_instr[15:0];

`ifdef FETCH_PERF_EN
    // Event counters: they clear on reset and stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stalls  <= '0;
            perf_flushes <= '0;
        end else begin
            if (doAdvance && (perf_fetched != 32'hFFFF_FFFF)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (doStall && (perf_stalls != 32'hFFFF_FFFF)) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
            if (doBranch && (perf_flushes != 32'hFFFF_FFFF)) begin
                perf_flushes <= perf_flushes + 32'd1;
            end
        end
    end
`endif

    // Only the word-address bits of the branch target are used.
    logic unusedTargetBits;
    assign unusedTargetBits = ^branch_target[1:0];

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random and directed stimulus for fetch_stage.
// A bench-side model of the PC and the IF/ID register is checked against the
// DUT on every cycle. Literal expectations taken from the scenarios fix the
// model itself.
module tb_fetch_stage;

    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_data;
    logic [31:0]     if_id_instr;
    logic [PC_W-1:0] if_id_pc4;
    logic            if_id_valid;
    logic [5:0]      op;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [5:0]      funct;
    logic [15:0]     imm;
`ifdef FETCH_PERF_EN
    logic [31:0]     perf_fetched;
    logic [31:0]     perf_stalls;
    logic [31:0]     perf_flushes;
`endif

    // Instruction memory: 256 words, indexed by the word address.
    logic [31:0] mem [256];
    assign imem_data = mem[imem_addr[9:2]];

    fetch_stage #(.PC_W(PC_W), .RESET_PC(32'h0), .NOP_WORD(32'h0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
`endif
    );

    // Clock generation.
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic checkOn = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, kept at the level of "what the pipeline should contain".
    logic [31:0] mPc, mInstr, mPc4;
    logic        mValid;
    longint      mFetched, mStalls, mFlushes;

    function automatic longint satInc(input longint v);
        return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
    endfunction

    // Model update, evaluated on every rising edge.
    always @(posedge clk) begin
        if (rst) begin
            mPc = 32'h0; mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
            mFetched = 0; mStalls = 0; mFlushes = 0;
        end else if (branch_taken) begin
            mPc = branch_target & ~32'h3;
            mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
            mFlushes = satInc(mFlushes);
        end else if (stall) begin
            mStalls = satInc(mStalls);
        end else begin
            mInstr = mem[mPc[9:2]];
            mPc4 = mPc + 32'd4;
            mValid = 1'b1;
            mPc = mPc + 32'd4;
            mFetched = satInc(mFetched);
        end
    end

    // Compare process: checks every output against the model on each falling edge.
    always @(negedge clk) begin
        if (checkOn) begin
            chk("imem_addr", imem_addr, mPc);
            chk("if_id_instr", if_id_instr, mInstr);
            chk("if_id_pc4", if_id_pc4, mPc4);
            chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, mValid});
            chk("op", {26'b0, op}, {26'b0, mInstr[31:26]});
            chk("rs", {27'b0, rs}, {27'b0, mInstr[25:21]});
            chk("rt", {27'b0, rt}, {27'b0, mInstr[20:16]});
            chk("rd", {27'b0, rd}, {27'b0, mInstr[15:11]});
            chk("shamt", {27'b0, shamt}, {27'b0, mInstr[10:6]});
            chk("funct", {26'b0, funct}, {26'b0, mInstr[5:0]});
            chk("imm", {16'b0, imm}, {16'b0, mInstr[15:0]});
`ifdef FETCH_PERF_EN
            chk("perf_fetched", perf_fetched, mFetched[31:0]);
            chk("perf_stalls", perf_stalls, mStalls[31:0]);
            chk("perf_flushes", perf_flushes, mFlushes[31:0]);
`endif
        end
    end

    // Driver: sets the inputs, then returns at the next falling edge, one active edge later.
    task automatic cyc(input logic r, input logic b, input logic [31:0] t, input logic s);
        rst = r; branch_taken = b; branch_target = t; stall = s;
        @(negedge clk);
    endtask

    logic [31:0] heldInstr;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h2008_0005;
        mem[1] = 32'h3509_00FF;
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        @(negedge clk);
        cyc(1, 0, 0, 0);
        checkOn = 1'b1;
        chk("reset imem_addr", imem_addr, 32'h0);
        chk("reset instr", if_id_instr, 32'h0);
        chk("reset valid", {31'b0, if_id_valid}, 32'h0);
        chk("reset pc4", if_id_pc4, 32'h0);

        // Free-running from reset.
        cyc(0, 0, 0, 0);
        chk("e1 op", {26'b0, op}, 32'h08);
        chk("e1 rt", {27'b0, rt}, 32'd8);
        chk("e1 imm", {16'b0, imm}, 32'd5);
        chk("e1 pc4", if_id_pc4, 32'h4);
        chk("e1 valid", {31'b0, if_id_valid}, 32'h1);
        cyc(0, 0, 0, 0);
        chk("e2 op", {26'b0, op}, 32'h0D);
        chk("e2 pc4", if_id_pc4, 32'h8);
        chk("e2 imem_addr", imem_addr, 32'h8);
        cyc(0, 0, 0, 0);

        // Stall for two cycles at pc=0x10.
        cyc(0, 1, 32'hC, 0);
        cyc(0, 0, 0, 0);
        heldInstr = mem[3];
        chk("pre-stall addr", imem_addr, 32'h10);
        for (int k = 0; k < 2; k++) begin
            cyc(0, 0, 0, 1);
            chk("stall addr", imem_addr, 32'h10);
            chk("stall instr", if_id_instr, heldInstr);
            chk("stall valid", {31'b0, if_id_valid}, 32'h1);
        end
        cyc(0, 0, 0, 0);
        chk("post-stall addr", imem_addr, 32'h14);
        chk("post-stall pc4", if_id_pc4, 32'h14);

        // Branch from 0x20 to an unaligned target.
        cyc(0, 1, 32'h20, 0);
        cyc(0, 1, 32'h103, 0);
        chk("br addr", imem_addr, 32'h100);
        chk("br instr", if_id_instr, 32'h0);
        chk("br valid", {31'b0, if_id_valid}, 32'h0);
        cyc(0, 0, 0, 0);
        chk("br+1 pc4", if_id_pc4, 32'h104);
        chk("br+1 valid", {31'b0, if_id_valid}, 32'h1);

        // A branch wins over a simultaneous stall.
        cyc(0, 1, 32'h40, 1);
        chk("br+stall addr", imem_addr, 32'h40);
        chk("br+stall instr", if_id_instr, 32'h0);
        chk("br+stall valid", {31'b0, if_id_valid}, 32'h0);

        // Reset mid-stream overrides stall and branch.
        cyc(0, 1, 32'h2C, 0);
        cyc(0, 0, 0, 0);
        chk("pre-rst addr", imem_addr, 32'h30);
        chk("pre-rst valid", {31'b0, if_id_valid}, 32'h1);
        cyc(1, 1, 32'h80, 1);
        chk("rst addr", imem_addr, 32'h0);
        chk("rst instr", if_id_instr, 32'h0);
        chk("rst valid", {31'b0, if_id_valid}, 32'h0);

        // PC wraps from the top of the address space.
        cyc(0, 1, 32'hFFFF_FFFC, 0);
        cyc(0, 0, 0, 0);
        chk("wrap addr", imem_addr, 32'h0);
        chk("wrap pc4", if_id_pc4, 32'h0);
        chk("wrap valid", {31'b0, if_id_valid}, 32'h1);

        // Performance-counter sequence after a reset.
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0);
        for (int k = 0; k < 2; k++) cyc(0, 0, 0, 1);
        cyc(0, 1, 32'h8, 0);
`ifdef FETCH_PERF_EN
        chk("perf fetched", perf_fetched, 32'd5);
        chk("perf stalls", perf_stalls, 32'd2);
        chk("perf flushes", perf_flushes, 32'd1);
`endif

        // Randomized stimulus.
        for (int k = 0; k < 600; k++) begin
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 7) == 0),
                $urandom,
                ($urandom_range(0, 3) == 0));
        end

        checkOn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
